// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receive path.
package uart_rx_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Data is stored at the widest supported size; narrower frames zero-fill the top.
    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     frame_err;
        logic                     parity_err;
    } rx_entry_t;

    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module uart_rx_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-vote sampling, false-start and break
// detection, receive FIFO with valid/ready read port.
//
//   state     | meaning
//   ST_IDLE   | line idle, waiting for a falling edge
//   ST_START  | qualifying the start bit at its middle
//   ST_DATA   | sampling data bits, LSB first
//   ST_PARITY | sampling the parity bit
//   ST_STOP   | sampling stop bit(s), push or break decision on the last
//   ST_BREAK  | line held low past a full frame, waiting for it to go high
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int           DATA_BITS    = 8,
    parameter parity_mode_t PARITY       = PAR_EVEN,
    parameter int           STOP_BITS    = 1,
    parameter int           OVERSAMPLING = 16,
    parameter int           FIFO_DEPTH   = 4
) (
    input  logic                          baud,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overrun,
    output logic                          break_det,
    input  logic                          err_clr
);
    localparam int              OS_W      = $clog2(OVERSAMPLING);
    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLING - 1);
    localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLING / 2 - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           rx_hist;
    logic                 maj;
    logic                 rx_fall;

    rx_state_t            state;
    rx_state_t            state_nxt;

    logic [OS_W-1:0]      os_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 stop_low;

    logic                 os_tc;
    logic                 os_half;
    logic                 stop_low_now;
    logic                 par_err;
    logic                 is_break;

    logic                 sample_data;
    logic                 sample_par;
    logic                 sample_stop;
    logic                 frame_done;
    logic                 push_req;
    logic                 break_set;

    logic                 push_vld;
    rx_entry_t            push_entry;
    rx_entry_t            head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 head_unused;

    // Synchroniser and vote history idle high so reset never looks like a start bit.
    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_hist <= 3'b111;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_hist <= {rx_hist[1:0], rx_s};
        end
    end

    assign maj     = (rx_hist[0] & rx_hist[1]) | (rx_hist[0] & rx_hist[2]) |
                     (rx_hist[1] & rx_hist[2]);
    assign rx_fall = rx_hist[0] & ~rx_s;
    assign os_tc   = (os_cnt == OS_LAST);
    assign os_half = (os_cnt == OS_HALF);

    assign stop_low_now = stop_low | ~maj;

    always_comb begin
        par_err = 1'b0;
        if (PARITY == PAR_EVEN) begin
            par_err = parity_of(MAX_DATA_BITS'(shift_reg)) ^ par_bit;
        end else if (PARITY == PAR_ODD) begin
            par_err = ~(parity_of(MAX_DATA_BITS'(shift_reg)) ^ par_bit);
        end
    end

    assign is_break = (shift_reg == '0) && ((PARITY == PAR_NONE) || !par_bit) &&
                      !stop_low && !maj;

    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (rx_fall) state_nxt = ST_START;
                ST_START:  if (os_half) state_nxt = maj ? ST_IDLE : ST_DATA;
                ST_DATA:   if (os_tc && bit_idx == DATA_LAST)
                               state_nxt = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                ST_PARITY: if (os_tc) state_nxt = ST_STOP;
                ST_STOP:   if (os_tc && bit_idx == STOP_LAST)
                               state_nxt = is_break ? ST_BREAK : ST_IDLE;
                ST_BREAK:  if (rx_s) state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        sample_data = (state == ST_DATA)   && os_tc;
        sample_par  = (state == ST_PARITY) && os_tc;
        sample_stop = (state == ST_STOP)   && os_tc;
        frame_done  = sample_stop && (bit_idx == STOP_LAST) && enable;
        push_req    = frame_done && !is_break;
        break_set   = frame_done && is_break;
    end

    // The bit clock restarts on entering START and again once the start bit is
    // confirmed, so every later sample lands one full bit after the start midpoint.
    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt    <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            stop_low  <= 1'b0;
        end else begin
            if (state == ST_IDLE || state_nxt == ST_IDLE ||
                (state == ST_START && state_nxt == ST_DATA)) begin
                os_cnt <= '0;
            end else begin
                os_cnt <= os_cnt + OS_W'(1);
            end

            if (state_nxt != state) begin
                bit_idx <= '0;
            end else if (sample_data || sample_stop) begin
                bit_idx <= bit_idx + 4'd1;
            end

            if (sample_data) begin
                shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
            end
            if (sample_par) begin
                par_bit <= maj;
            end

            if (state != ST_STOP) begin
                stop_low <= 1'b0;
            end else if (sample_stop && !maj) begin
                stop_low <= 1'b1;
            end
        end
    end

    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            push_vld   <= 1'b0;
            push_entry <= '0;
        end else begin
            push_vld <= push_req;
            if (push_req) begin
                push_entry <= '{data:       MAX_DATA_BITS'(shift_reg),
                                frame_err:  stop_low_now,
                                parity_err: par_err};
            end
        end
    end

    uart_rx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rx_entry_t))
    ) u_fifo (
        .clk     (baud),
        .rst_n   (rst_n),
        .push    (push_vld),
        .wr_data (push_entry),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign rd_valid      = !fifo_empty;
    assign pop           = rd_valid && rd_ready;
    assign rd_data       = head.data[DATA_BITS-1:0];
    assign rd_frame_err  = head.frame_err;
    assign rd_parity_err = head.parity_err;
    assign head_unused   = ^head.data;

    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            if (push_vld && fifo_full && !pop) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (break_set) begin
                break_det <= 1'b1;
            end else if (err_clr) begin
                break_det <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param (8E1, x16, depth 4): queue-based frame model checked
// every cycle, plus directed literal checks on key frames.
module tb_uart_rx_param;
    import uart_rx_pkg::*;

    localparam int DB          = 8;
    localparam int OS          = 16;
    localparam int DEPTH       = 4;
    localparam int FRAME_TICKS = 11 * OS;
    // Start bit driven just after edge N: word visible after edge N+172,
    // break flag after edge N+171 (sync 2, START entry 1, mid-bit sampling).
    localparam int PUSH_LAT    = 172;
    localparam int BREAK_LAT   = 171;

    logic          baud     = 1'b0;
    logic          rst_n    = 1'b1;
    logic          enable   = 1'b0;
    logic          rx       = 1'b1;
    logic          rd_ready = 1'b0;
    logic          err_clr  = 1'b0;
    logic [DB-1:0] rd_data;
    logic          rd_frame_err;
    logic          rd_parity_err;
    logic          rd_valid;
    logic [2:0]    fifo_count;
    logic          busy;
    logic          overrun;
    logic          break_det;

    uart_rx_param #(
        .DATA_BITS    (DB),
        .PARITY       (PAR_EVEN),
        .STOP_BITS    (1),
        .OVERSAMPLING (OS),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .baud          (baud),
        .rst_n         (rst_n),
        .enable        (enable),
        .rx            (rx),
        .rd_data       (rd_data),
        .rd_frame_err  (rd_frame_err),
        .rd_parity_err (rd_parity_err),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .fifo_count    (fifo_count),
        .busy          (busy),
        .overrun       (overrun),
        .break_det     (break_det),
        .err_clr       (err_clr)
    );

    always #5 baud = ~baud;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    typedef struct {
        int   due;
        bit   brk;
        exp_t e;
    } sched_t;

    exp_t   mq[$];
    sched_t sq[$];
    bit     m_ov;
    bit     m_brk;
    int     cyc;
    int     checks;
    int     errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge baud) begin : model
        bit set_ov;
        bit set_brk;
        cyc++;
        if (rst_n) begin
            set_ov  = 1'b0;
            set_brk = 1'b0;
            if (mq.size() > 0 && rd_ready) void'(mq.pop_front());
            while (sq.size() > 0 && sq[0].due <= cyc) begin
                if (sq[0].brk) set_brk = 1'b1;
                else if (mq.size() < DEPTH) mq.push_back(sq[0].e);
                else set_ov = 1'b1;
                void'(sq.pop_front());
            end
            if (set_ov) m_ov = 1'b1;
            else if (err_clr) m_ov = 1'b0;
            if (set_brk) m_brk = 1'b1;
            else if (err_clr) m_brk = 1'b0;
        end
    end

    always @(negedge baud) begin
        check("status", 32'({rd_valid, fifo_count, overrun, break_det}),
              32'({mq.size() > 0, 3'(mq.size()), m_ov, m_brk}));
        if (mq.size() > 0)
            check("head", 32'({rd_data, rd_frame_err, rd_parity_err}),
                  32'({mq[0].d, mq[0].fe, mq[0].pe}));
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge baud);
    endtask

    // Called on a falling clock edge; abort_at >= 0 stops driving after that many ticks.
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                              input int abort_at);
        logic [10:0] bits;
        sched_t      s;
        bits = {sb, pb, d, 1'b0};
        if (abort_at < 0) begin
            s.e.d  = d;
            s.e.fe = ~sb;
            s.e.pe = (^d) ^ pb;
            s.brk  = (d == 8'h00) && !pb && !sb;
            s.due  = cyc + (s.brk ? BREAK_LAT : PUSH_LAT);
            sq.push_back(s);
        end
        for (int t = 0; t < FRAME_TICKS; t++) begin
            if (t == abort_at) break;
            rx = bits[t / OS];
            @(negedge baud);
        end
        rx = 1'b1;
    endtask

    task automatic send_break(input int n);
        sched_t s;
        s.e.d  = 8'h00;
        s.e.fe = 1'b1;
        s.e.pe = 1'b0;
        s.brk  = 1'b1;
        s.due  = cyc + BREAK_LAT;
        sq.push_back(s);
        rx = 1'b0;
        ticks(n);
        rx = 1'b1;
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        ticks(1);
        rd_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        ticks(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        ticks(3);
        check("rst_valid", rd_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_break", break_det, 0);
        check("rst_data", 32'({rd_data, rd_frame_err, rd_parity_err}), 0);
        #2 rst_n = 1'b1;
        enable = 1'b1;
        ticks(5);

        // Clean frame, also pins the start-to-busy latency.
        fork
            send_frame(8'hA5, 1'b0, 1'b1, -1);
            begin
                ticks(2);
                check("busy_lat_2", busy, 0);
                ticks(1);
                check("busy_lat_3", busy, 1);
            end
        join
        check("a5_valid", rd_valid, 1);
        check("a5_word", 32'({rd_data, rd_frame_err, rd_parity_err}), 32'({8'hA5, 2'b00}));
        pop_one();

        send_frame(8'h01, 1'b0, 1'b1, -1);
        check("par_err_word", 32'({rd_data, rd_frame_err, rd_parity_err}), 32'({8'h01, 2'b01}));
        pop_one();

        send_frame(8'h3C, 1'b0, 1'b0, -1);
        check("frm_err_word", 32'({rd_data, rd_frame_err, rd_parity_err}), 32'({8'h3C, 2'b10}));
        pop_one();

        // Short glitch: false start.
        rx = 1'b0;
        ticks(4);
        check("glitch_start", busy, 1);
        rx = 1'b1;
        ticks(20);
        check("glitch_idle", busy, 0);
        check("glitch_count", fifo_count, 0);

        // Overrun on the fifth unread word.
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d;
            d = 8'h10 + 8'(i);
            send_frame(d, ^d, 1'b1, -1);
        end
        check("ovr_count", fifo_count, 4);
        check("ovr_flag", overrun, 1);
        for (int i = 0; i < 4; i++) begin
            check("ovr_read", rd_data, 32'(8'h10 + i));
            pop_one();
        end
        check("ovr_drained", rd_valid, 0);
        pulse_clr();
        check("ovr_cleared", overrun, 0);

        // Push and pop on the same edge while full.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'h20 + 8'(i);
            send_frame(d, ^d, 1'b1, -1);
        end
        fork
            send_frame(8'h24, 1'b0, 1'b1, -1);
            begin
                ticks(PUSH_LAT - 1);
                rd_ready = 1'b1;
                ticks(1);
                rd_ready = 1'b0;
            end
        join
        check("full_pp_count", fifo_count, 4);
        check("full_pp_ovr", overrun, 0);
        check("full_pp_head", rd_data, 8'h21);
        for (int i = 0; i < 4; i++) pop_one();

        // Break: two frame times low.
        send_break(2 * FRAME_TICKS);
        ticks(5);
        check("brk_flag", break_det, 1);
        check("brk_busy", busy, 0);
        check("brk_count", fifo_count, 0);
        send_frame(8'h55, 1'b0, 1'b1, -1);
        check("post_brk_word", 32'({rd_data, rd_frame_err, rd_parity_err}), 32'({8'h55, 2'b00}));
        pulse_clr();
        check("brk_cleared", break_det, 0);

        // Reset mid-data with one word still queued.
        send_frame(8'h96, 1'b0, 1'b1, 40);
        check("rstmid_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        mq.delete();
        sq.delete();
        m_ov  = 1'b0;
        m_brk = 1'b0;
        ticks(2);
        check("rstmid_busy", busy, 0);
        check("rstmid_count", fifo_count, 0);
        #2 rst_n = 1'b1;
        ticks(200);
        check("rstmid_nopush", rd_valid, 0);

        // Enable dropped mid-frame, then a clean frame.
        send_frame(8'h5A, 1'b0, 1'b1, 90);
        check("en_busy_pre", busy, 1);
        enable = 1'b0;
        ticks(1);
        check("en_busy", busy, 0);
        ticks(200);
        check("en_nopush", fifo_count, 0);
        enable = 1'b1;
        ticks(5);
        send_frame(8'hC3, 1'b0, 1'b1, -1);
        check("en_next_word", 32'({rd_data, rd_frame_err, rd_parity_err}), 32'({8'hC3, 2'b00}));
        pop_one();
        ticks(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
